fir_mac_seq: RTL and testbench
==============================

Name: fir_mac_seq

Overview:
- Parametrised time-multiplexed FIR filter with one shared multiplier and accumulator, iterated over TAPS coefficients per sample.
- Serially loaded coefficient bank, valid/ready input and output handshakes, full-precision output.
- Successor to the fixed 4-tap, 8-bit filter datapath. Sits between the sample source and downstream consumer in the filter core.

Parameters:
- DW, 8, sample width in bits.
- CW, 8, coefficient width in bits.
- TAPS, 4, number of taps; minimum 2.
- AW, DW+CW+$clog2(TAPS), accumulator/output width (derived localparam, not overridable).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- coef_shift_en  in  1  shift one coefficient bit in this cycle.
- coef_in  in  1  serial coefficient bit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DW  input sample.
- out_valid  out  1  out_data holds a new result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  AW  filter result.
- busy  out  1  high in the MAC and DONE states.

Behaviour:
- Reset: c[], d[], acc and out_data clear to 0; state goes to IDLE; out_valid=0; busy=0.
- Coefficient bank: the TAPS*CW vector {c[TAPS-1],...,c[0]} shifts left by 1 on each edge with coef_shift_en=1 in IDLE. coef_in enters bit 0 of c[0], and the MSB of c[k] feeds bit 0 of c[k+1]. The first bit shifted ends at the MSB of c[TAPS-1] after TAPS*CW shifts.
- coef_shift_en outside IDLE is ignored; coefficients stay unchanged.
- in_ready = (state==IDLE) && !coef_shift_en. A coefficient shift always wins over a sample accept.
- Accept: at the edge where in_valid && in_ready:
  - d[0]<=in_data and d[k]<=d[k-1];
  - acc<=0, idx<=0, state<=MAC.
- MAC: on each edge, acc += d[idx]*c[idx] and idx++. Products are DW+CW bits, zero-extended to AW.
  - After TAPS edges (idx==TAPS-1 accumulated), out_data<=final sum and state<=DONE.
  - The final sum is written straight to out_data; acc is not read back an extra cycle.
- DONE: out_valid=1, out_data held stable. The edge with out_ready=1 returns state to IDLE.
- out_data keeps its last value after the handshake; only out_valid drops.
- Latency: out_valid rises TAPS edges after the accept edge. Minimum sample period is TAPS+2 cycles (accept, TAPS MAC cycles, DONE with out_ready=1). Samples never overlap.
- Back-pressure: DONE lasts indefinitely while out_ready=0. in_ready stays 0 and nothing changes.
- Overflow: AW is sized so the TAPS-term unsigned full-scale sum cannot overflow. No wrap or saturation is needed.
- Reset mid-operation: an asynchronous reset_n assertion in MAC or DONE aborts immediately. The partial result is discarded, the delay line and coefficients clear, and no out_valid is produced.
- in_valid while not ready is not consumed. The source holds in_data until in_ready.

Optional Feature:
- Macro: FIR_MAC_SIGNED_EN.
- Defined: d[] and c[] are two's complement. Products are signed DW+CW bits, sign-extended to AW, and out_data is a signed AW-bit value. AW is unchanged, which covers the worst case (-2^(DW-1))*(-2^(CW-1))*TAPS.
- Undefined: all arithmetic is unsigned with zero extension, as described above.

Test Plan:
- Coefficient load (TAPS=4, DW=CW=8): shift 32 bits so c0=1, c1=2, c2=3, c3=4.
  - Samples 10,20,30,40,50 with out_ready=1 -> results 10, 40, 100, 200, 300.
  - out_valid appears 4 edges after each accept; in_ready is low between accept and the DONE handshake.
- Full scale: all coefs 255, five samples of 255 -> 4th and 5th results = 260100 (0x3F804), no overflow in 18 bits.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0, and a pending in_valid is not consumed until 1 cycle after out_ready.
- Shift priority and lockout:
  - coef_shift_en=1 with in_valid=1 in IDLE -> in_ready=0, coefficient shifts, no accept.
  - coef_shift_en pulsed during MAC -> coefficients unchanged and the result matches the pre-pulse coefficients.
- Reset mid-MAC: drop reset_n for 1 cycle at idx=2 -> out_valid stays 0 and all registers read 0. The next sample with reloaded coefs gives the correct result from a zero delay line.
- With FIR_MAC_SIGNED_EN: c0=0xFF (-1), other coefs 0, sample 0x80 (-128) -> out_data=+128. With c0=0x7F (127) and the same sample -> out_data = -16256 (two's complement in 18 bits).

Source files
------------

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR filter: one shared MAC iterates over TAPS coefficients.
// Define FIR_MAC_SIGNED_EN for two's-complement samples and coefficients.
module fir_mac_seq #(
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int TAPS = 4,
    localparam int AW = DW + CW + $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          coef_shift_en,
    input  logic          coef_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          busy
);

    localparam int IW = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int CB = TAPS * CW;
    localparam int DB = TAPS * DW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CB-1:0] r_coef;
    logic [DB-1:0] r_data;
    logic [AW-1:0] r_acc;
    logic [IW-1:0] r_idx;
    logic [AW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_busy;

    logic [DW-1:0] w_d;
    logic [CW-1:0] w_c;
    logic [PW-1:0] w_d_ext;
    logic [PW-1:0] w_c_ext;
    logic [PW-1:0] w_prod_raw;
    logic [AW-1:0] w_prod;
    logic [AW-1:0] w_sum;
    logic          w_last;

    assign w_d = r_data[r_idx*DW +: DW];
    assign w_c = r_coef[r_idx*CW +: CW];

    // Low PW bits of the extended product equal the exact product in both modes
`ifdef FIR_MAC_SIGNED_EN
    assign w_d_ext = {{CW{w_d[DW-1]}}, w_d};
    assign w_c_ext = {{DW{w_c[CW-1]}}, w_c};
    assign w_prod_raw = w_d_ext * w_c_ext;
    assign w_prod = {{(AW-PW){w_prod_raw[PW-1]}}, w_prod_raw};
`else
    assign w_d_ext = {{CW{1'b0}}, w_d};
    assign w_c_ext = {{DW{1'b0}}, w_c};
    assign w_prod_raw = w_d_ext * w_c_ext;
    assign w_prod = {{(AW-PW){1'b0}}, w_prod_raw};
`endif

    assign w_sum = r_acc + w_prod;
    assign w_last = (r_idx == IW'(TAPS - 1));

    assign in_ready = (r_state == S_IDLE) && !coef_shift_en;
    assign out_valid = r_out_valid;
    assign out_data = r_out_data;
    assign busy = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_coef      <= '0;
            r_data      <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (coef_shift_en) begin
                        r_coef <= {r_coef[CB-2:0], coef_in};
                    end else if (in_valid) begin
                        r_data  <= {r_data[DB-DW-1:0], in_data};
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_out_data  <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomised self-checking bench for fir_mac_seq against a sum-of-products model.
// Honours FIR_MAC_SIGNED_EN in the reference model.
module tb_fir_mac_seq;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int TAPS = 4;
    localparam int AW = DW + CW + $clog2(TAPS);
    localparam int CB = TAPS * CW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          coef_shift_en = 1'b0;
    logic          coef_in = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_data;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // model state: coefficient list and the last TAPS accepted samples
    logic [CW-1:0] m_c[TAPS];
    logic [DW-1:0] m_h[TAPS];

    fir_mac_seq #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .coef_shift_en(coef_shift_en),
        .coef_in(coef_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] model_out();
        longint s = 0;
        longint dv;
        longint cv;
        for (int k = 0; k < TAPS; k++) begin
`ifdef FIR_MAC_SIGNED_EN
            dv = longint'($signed(m_h[k]));
            cv = longint'($signed(m_c[k]));
`else
            dv = longint'(m_h[k]);
            cv = longint'(m_c[k]);
`endif
            s += dv * cv;
        end
        return s[AW-1:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) begin
            m_c[k] = '0;
            m_h[k] = '0;
        end
    endtask

    // first bit sent lands at the MSB of the last coefficient
    task automatic load_coefs(input logic [CW-1:0] c[TAPS]);
        logic [CB-1:0] v;
        for (int k = 0; k < TAPS; k++) v[k*CW +: CW] = c[k];
        coef_shift_en = 1'b1;
        for (int i = CB - 1; i >= 0; i--) begin
            coef_in = v[i];
            tick();
        end
        coef_shift_en = 1'b0;
        for (int k = 0; k < TAPS; k++) m_c[k] = c[k];
    endtask

    task automatic do_accept(input logic [DW-1:0] d);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("acc_rdy", in_ready, 1);
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
        for (int k = TAPS - 1; k > 0; k--) m_h[k] = m_h[k-1];
        m_h[0] = d;
    endtask

    task automatic wait_result(input string tag, input int start);
        int lat = start;
        logic rdy_seen = 1'b0;
        while (!out_valid && lat < 50) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, TAPS);
        check({tag, "_rdylo"}, rdy_seen, 0);
        check(tag, out_data, model_out());
    endtask

    task automatic handshake(input int bp);
        logic [AW-1:0] held = out_data;
        logic bad = 1'b0;
        for (int i = 0; i < bp; i++) begin
            tick();
            if (!out_valid || out_data !== held || in_ready || !busy)
                bad = 1'b1;
        end
        check("bp_hold", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_vld", out_valid, 0);
        check("hs_data", out_data, held);
        check("hs_busy", busy, 0);
    endtask

    logic [CW-1:0] cs[TAPS];
    logic [AW-1:0] exp_tab[5];
    logic [AW-1:0] snap;
    logic          flag;

    initial begin
        model_clear();
        exp_tab[0] = 10;
        exp_tab[1] = 40;
        exp_tab[2] = 100;
        exp_tab[3] = 200;
        exp_tab[4] = 300;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", out_data, 0);
        check("rst_rdy", in_ready, 1);
        reset_n = 1'b1;
        tick();

        for (int k = 0; k < TAPS; k++) cs[k] = CW'(k + 1);
        load_coefs(cs);
        for (int i = 0; i < 5; i++) begin
            do_accept(DW'(10 * (i + 1)));
            wait_result("ramp", 0);
            check("ramp_tab", out_data, exp_tab[i]);
            handshake(0);
        end

        for (int k = 0; k < TAPS; k++) cs[k] = '1;
        load_coefs(cs);
        for (int i = 0; i < 5; i++) begin
            do_accept('1);
            wait_result("fullscale", 0);
            handshake(0);
        end

        // back-pressure with a sample waiting on the input
        do_accept(8'd77);
        wait_result("bp", 0);
        in_valid = 1'b1;
        in_data = 8'd33;
        snap = out_data;
        handshake(5);
        check("bp_pend_rdy", in_ready, 1);
        do_accept(8'd33);
        check("bp_pend_busy", busy, 1);
        wait_result("bp_pend", 0);
        handshake(1);

        // shift wins over accept
        in_valid = 1'b1;
        in_data = 8'd5;
        coef_shift_en = 1'b1;
        coef_in = 1'b1;
        #1;
        check("prio_rdy", in_ready, 0);
        tick();
        coef_shift_en = 1'b0;
        in_valid = 1'b0;
        check("prio_busy", busy, 0);
        for (int k = TAPS - 1; k > 0; k--)
            m_c[k] = {m_c[k][CW-2:0], m_c[k-1][CW-1]};
        m_c[0] = {m_c[0][CW-2:0], 1'b1};
        do_accept(8'd5);
        wait_result("prio", 0);
        handshake(0);

        // shift during MAC is ignored
        do_accept(8'd9);
        coef_shift_en = 1'b1;
        coef_in = 1'b0;
        tick();
        tick();
        coef_shift_en = 1'b0;
        wait_result("lock", 2);
        handshake(0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < TAPS; k++) cs[k] = CW'($urandom);
            load_coefs(cs);
            for (int i = 0; i < 6; i++) begin
                do_accept(DW'($urandom));
                wait_result("rand", 0);
                handshake($urandom_range(0, 2));
            end
        end

        // reset in the middle of MAC
        do_accept(8'd100);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_vld", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_data", out_data, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || busy) flag = 1'b1;
        end
        check("mid_quiet", flag, 0);
        for (int k = 0; k < TAPS; k++) cs[k] = CW'(k + 1);
        load_coefs(cs);
        do_accept(8'd7);
        wait_result("after_rst", 0);
        handshake(0);

`ifdef FIR_MAC_SIGNED_EN
        model_clear();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < TAPS; k++) cs[k] = '0;
        cs[0] = 8'hFF;
        load_coefs(cs);
        do_accept(8'h80);
        wait_result("sgn_neg1", 0);
        handshake(0);
        cs[0] = 8'h7F;
        load_coefs(cs);
        do_accept(8'h80);
        wait_result("sgn_pos127", 0);
        handshake(0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
